// File: rtl/hog_gradient_ctrl.sv
// hog_gradient_ctrl: frame sequencer for hog_gradient; forwards interior kernels
// and tags each Gx/Gy result with its interior column/row and end-of-frame flag.
module hog_gradient_ctrl #(
    parameter int IMG_WIDTH    = 64,
    parameter int IMG_HEIGHT   = 128,
    parameter int KERNEL_WIDTH = 72,
    parameter int TAG_DEPTH    = 4,
    localparam int CW = $clog2(IMG_WIDTH),
    localparam int RW = $clog2(IMG_HEIGHT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [KERNEL_WIDTH-1:0] s_kernel,
    output logic                    k_valid,
    input  logic                    k_ready,
    output logic [KERNEL_WIDTH-1:0] kernel,
    input  logic                    g_valid,
    output logic                    g_ready,
    input  logic [8:0]              g_gx,
    input  logic [8:0]              g_gy,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [8:0]              m_gx,
    output logic [8:0]              m_gy,
    output logic [CW-1:0]           m_col,
    output logic [RW-1:0]           m_row,
    output logic                    m_last
);
    localparam int AW = $clog2(TAG_DEPTH);
    localparam logic [CW-1:0] X_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] Y_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] X_TAIL = CW'(IMG_WIDTH - 2);
    localparam logic [RW-1:0] Y_TAIL = RW'(IMG_HEIGHT - 2);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   x;
    logic [RW-1:0]   y;
    logic            last_out;
    logic [CW-1:0]   col_mem [TAG_DEPTH];
    logic [RW-1:0]   row_mem [TAG_DEPTH];
    logic [TAG_DEPTH-1:0] last_mem;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            tag_full, tag_empty, interior, running;
    logic            in_hs, out_hs, push, frame_end, last_hs;

    assign tag_full  = count == (AW+1)'(TAG_DEPTH);
    assign tag_empty = count == '0;
    assign running   = state == RUN;
    assign interior  = x != '0 && x != X_LAST && y != '0 && y != Y_LAST;

    // Border kernels are swallowed regardless of downstream readiness.
    assign k_valid = running && interior && s_valid && !tag_full;
    assign s_ready = running && (!interior || (k_ready && !tag_full));
    assign kernel  = s_kernel;
    assign in_hs   = s_valid && s_ready;
    assign push    = in_hs && interior;

    assign m_valid = g_valid && !tag_empty;
    assign g_ready = m_ready && !tag_empty;
    assign m_gx    = g_gx;
    assign m_gy    = g_gy;
    assign m_col   = tag_empty ? '0 : col_mem[rd_ptr];
    assign m_row   = tag_empty ? '0 : row_mem[rd_ptr];
    assign m_last  = !tag_empty && last_mem[rd_ptr];
    assign out_hs  = m_valid && m_ready;

    assign frame_end = in_hs && x == X_LAST && y == Y_LAST;
    assign last_hs   = out_hs && m_last;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? RUN : IDLE;
            RUN:     state_nx = !frame_end ? RUN : (last_out || last_hs) ? DONE : DRAIN;
            DRAIN:   state_nx = last_out ? DONE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            x        <= '0;
            y        <= '0;
            last_out <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            state <= state_nx;
            busy  <= state_nx != IDLE;
            done  <= state_nx == DONE;
            if (state == IDLE && start) begin
                x        <= '0;
                y        <= '0;
                last_out <= 1'b0;
            end else begin
                if (in_hs) begin
                    x <= x == X_LAST ? '0 : x + CW'(1);
                    if (x == X_LAST) y <= y == Y_LAST ? '0 : y + RW'(1);
                end
                if (last_hs) last_out <= 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (out_hs) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(out_hs);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            col_mem[wr_ptr]  <= x - CW'(1);
            row_mem[wr_ptr]  <= y - RW'(1);
            last_mem[wr_ptr] <= x == X_TAIL && y == Y_TAIL;
        end
    end
endmodule

// File: tb/tb_hog_gradient_ctrl.sv
// tb_hog_gradient_ctrl: three controller configurations driven with random
// handshakes, checked against a raster-order tag list and a queued gradient stub.
module tb_hog_gradient_ctrl;
    localparam int WS [3] = '{4, 6, 3};
    localparam int HS [3] = '{4, 6, 3};
    localparam int DS [3] = '{2, 4, 4};

    logic        clk, rst;
    logic        start [3], s_valid [3], k_ready [3], g_valid [3], m_ready [3];
    logic [71:0] s_kernel [3];
    logic [8:0]  g_gx [3], g_gy [3];
    logic        busy [3], done [3], s_ready [3], k_valid [3], g_ready [3], m_valid [3], m_last [3];
    logic [71:0] kernel [3];
    logic [8:0]  m_gx [3], m_gy [3];
    logic [7:0]  m_col [3], m_row [3];
    int          passed = 0, total = 0;

    for (genvar g = 0; g < 3; g++) begin : dut_g
        localparam int CWG = $clog2(WS[g]);
        localparam int RWG = $clog2(HS[g]);
        logic [CWG-1:0] col;
        logic [RWG-1:0] row;
        hog_gradient_ctrl #(.IMG_WIDTH(WS[g]), .IMG_HEIGHT(HS[g]), .KERNEL_WIDTH(72), .TAG_DEPTH(DS[g])) dut (
            .clk(clk), .rst(rst), .start(start[g]), .busy(busy[g]), .done(done[g]),
            .s_valid(s_valid[g]), .s_ready(s_ready[g]), .s_kernel(s_kernel[g]),
            .k_valid(k_valid[g]), .k_ready(k_ready[g]), .kernel(kernel[g]),
            .g_valid(g_valid[g]), .g_ready(g_ready[g]), .g_gx(g_gx[g]), .g_gy(g_gy[g]),
            .m_valid(m_valid[g]), .m_ready(m_ready[g]), .m_gx(m_gx[g]), .m_gy(m_gy[g]),
            .m_col(col), .m_row(row), .m_last(m_last[g])
        );
        assign m_col[g] = 8'(col);
        assign m_row[g] = 8'(row);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        else passed++;
    endtask

    task automatic idle_inputs(input int sel);
        start[sel] = 0; s_valid[sel] = 0; k_ready[sel] = 0; g_valid[sel] = 0; m_ready[sel] = 0;
        s_kernel[sel] = '0; g_gx[sel] = '0; g_gy[sel] = '0;
    endtask

    task automatic check_zero(input int sel);
        check("zero_busy", busy[sel], 0);
        check("zero_done", done[sel], 0);
        check("zero_s_ready", s_ready[sel], 0);
        check("zero_k_valid", k_valid[sel], 0);
        check("zero_g_ready", g_ready[sel], 0);
        check("zero_m_valid", m_valid[sel], 0);
        check("zero_m_last", m_last[sel], 0);
        check("zero_m_col", m_col[sel], 0);
        check("zero_m_row", m_row[sel], 0);
    endtask

    // mode 0: random, 1: output stalled early, 2: last in/out same cycle, 3: full flow
    task automatic run_frame(input int sel, input int mode, input int abort_at);
        int w, h, d, n, idx, dones, khs, x, y;
        bit border, room, ihs, ohs;
        logic [95:0] r;
        logic [71:0] kk;
        logic [71:0] kq [$];
        int ecol [$], erow [$], elast [$];
        w = WS[sel]; h = HS[sel]; d = DS[sel]; n = w * h;
        for (int yy = 1; yy < h - 1; yy++)
            for (int xx = 1; xx < w - 1; xx++) begin
                ecol.push_back(xx - 1);
                erow.push_back(yy - 1);
                elast.push_back((xx == w - 2 && yy == h - 2) ? 1 : 0);
            end
        idle_inputs(sel);
        start[sel] = 1;
        @(negedge clk);
        start[sel] = 0;
        #1;
        check("busy_after_start", busy[sel], 1);
        idx = 0; dones = 0; khs = 0;
        for (int cyc = 0; cyc < 2000 && dones == 0; cyc++) begin
            r = {$urandom(), $urandom(), $urandom()};
            s_valid[sel]  = idx < n && (mode != 0 || $urandom_range(3) != 0);
            s_kernel[sel] = r[71:0];
            k_ready[sel]  = idx != 0 && (mode != 0 || $urandom_range(3) != 0);
            m_ready[sel]  = mode == 1 ? (cyc >= 60 && $urandom_range(1) == 1) :
                            mode == 2 ? idx >= n - 1 : mode == 3 ? 1'b1 : $urandom_range(3) != 0;
            g_valid[sel]  = kq.size() > 0 && (mode != 0 || $urandom_range(2) != 0);
            kk = kq.size() > 0 ? kq[0] : r[95:24];
            g_gx[sel] = kk[8:0];
            g_gy[sel] = kk[17:9];
            start[sel] = $urandom_range(3) == 0;
            #1;
            if (cyc == abort_at) begin
                #2 rst = 0;
                #1 check_zero(sel);
                @(negedge clk);
                rst = 1;
                idle_inputs(sel);
                return;
            end
            x = idx % w; y = idx / w;
            border = x == 0 || x == w - 1 || y == 0 || y == h - 1;
            room = kq.size() < d;
            if (idx < n) begin
                if (border) begin
                    check("border_s_ready", s_ready[sel], 1);
                    check("border_k_valid", k_valid[sel], 0);
                end else begin
                    check("int_k_valid", k_valid[sel], s_valid[sel] && room);
                    check("int_s_ready", s_ready[sel], k_ready[sel] && room);
                    if (k_valid[sel]) check("kernel", kernel[sel], s_kernel[sel]);
                end
            end else check("input_closed", s_ready[sel], 0);
            check("m_valid", m_valid[sel], g_valid[sel] && kq.size() > 0);
            ihs = s_valid[sel] && s_ready[sel];
            ohs = m_valid[sel] && m_ready[sel];
            if (ohs) begin
                if (ecol.size() == 0) check("extra_output", 1, 0);
                else begin
                    kk = kq.pop_front();
                    check("m_gx", m_gx[sel], kk[8:0]);
                    check("m_gy", m_gy[sel], kk[17:9]);
                    check("m_col", m_col[sel], ecol.pop_front());
                    check("m_row", m_row[sel], erow.pop_front());
                    check("m_last", m_last[sel], elast.pop_front());
                end
            end
            if (ihs) begin
                if (!border) begin
                    kq.push_back(s_kernel[sel]);
                    khs++;
                end
                idx++;
            end
            dones += int'(done[sel]);
            @(negedge clk);
        end
        idle_inputs(sel);
        for (int i = 0; i < 4; i++) begin
            #1 dones += int'(done[sel]);
            @(negedge clk);
        end
        #1;
        check("done_pulses", dones, 1);
        check("k_handshakes", khs, (w - 2) * (h - 2));
        check("tags_left", ecol.size(), 0);
        check("busy_after_done", busy[sel], 0);
        check("inputs_taken", idx, n);
    endtask

    initial begin
        rst = 1;
        for (int g = 0; g < 3; g++) idle_inputs(g);
        #2 rst = 0;
        #1;
        for (int g = 0; g < 3; g++) check_zero(g);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        run_frame(0, 3, -1);
        run_frame(0, 0, -1);
        run_frame(0, 0, -1);
        run_frame(1, 1, -1);
        run_frame(1, 0, -1);
        run_frame(1, 0, 15);
        run_frame(1, 3, -1);
        run_frame(2, 2, -1);
        run_frame(2, 3, -1);
        run_frame(2, 0, -1);
        run_frame(2, 0, -1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
